frame_fifo_sync_ctrl: RTL and testbench



---
 rtl/frame_fifo_sync_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_frame_fifo_sync_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_fifo_sync_ctrl.sv
// ---------------------------------------------------------------------------
// frame_fifo_sync_ctrl
//
// Single-clock frame FIFO for one switch port. It sits between the ingress MAC
// parser and the forwarding engine. The block holds the write/read pointer
// controller and an inferred dual-port RAM array.
//
// Optional feature: define FRAME_FIFO_PEAK_LEVEL_EN to add a peak fill-level
// tracker (ports PEAK_CLR / PEAK_LEVEL).
//
// Parameters:
//   WIDTH     data word width (1..256)
//   DEPTH     number of entries, power of two (4..4096)
//   PIPE      0: RDATA one cycle after an accepted read
//             1: extra output register, two cycles
//   AFULL_TH  AFULL  asserted when LEVEL >= AFULL_TH
//   AEMPTY_TH AEMPTY asserted when LEVEL <= AEMPTY_TH
//
// Ports:
//   CLOCK      rising-edge clock
//   RESET_N    asynchronous active-low reset
//   WE/WDATA   write request and write data
//   RE         read request
//   RDATA      read data, held while RVALID=0
//   RVALID     RDATA carries a newly read word this cycle
//   FULL/EMPTY/AFULL/AEMPTY   registered occupancy flags
//   LEVEL      occupancy, 0..DEPTH
//   OVERFLOW   one-cycle strobe when a write is rejected
//   UNDERFLOW  one-cycle strobe when a read is rejected
//   PEAK_CLR   (optional) reload the peak tracker with the current LEVEL
//   PEAK_LEVEL (optional) highest LEVEL since reset or the last PEAK_CLR
// ---------------------------------------------------------------------------
module frame_fifo_sync_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int PIPE      = 1,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     WE,
  input  logic [WIDTH-1:0]         WDATA,
  input  logic                     RE,
  output logic [WIDTH-1:0]         RDATA,
  output logic                     RVALID,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     AFULL,
  output logic                     AEMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
  ,
  input  logic                     PEAK_CLR,
  output logic [$clog2(DEPTH):0]   PEAK_LEVEL
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   LVL_AEMPT = (AW+1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [AW:0]      level_next;
  logic             full_reg;
  logic             empty_reg;
  logic             afull_reg;
  logic             aempty_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic [WIDTH-1:0] ram_q_reg;
  logic             ram_v_reg;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags from the start of the cycle, so a
  // read and a write in the same cycle never interact combinationally.
  always_comb begin
    wr_acc     = WE && !full_reg;
    rd_acc     = RE && !empty_reg;
    level_next = level_reg;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase
  end

  // RAM write port. Storage is never reset.
  always_ff @(posedge CLOCK) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= WDATA;
    end
  end

  // Pointer, level, flag and registered-read state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      ram_q_reg     <= '0;
      ram_v_reg     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        // The read address is never the one being written this cycle,
        // because the FIFO cannot be empty at that slot.
        ram_q_reg  <= mem[rd_ptr_reg];
      end
      ram_v_reg     <= rd_acc;
      level_reg     <= level_next;
      full_reg      <= (level_next == LVL_FULL);
      empty_reg     <= (level_next == '0);
      afull_reg     <= (level_next >= LVL_AFULL);
      aempty_reg    <= (level_next <= LVL_AEMPT);
      overflow_reg  <= WE && full_reg;
      underflow_reg <= RE && empty_reg;
    end
  end

  // Read output stage: direct from the RAM register, or through one more
  // register for timing closure on wide words.
  generate
    if (PIPE == 0) begin : g_pipe0
      assign RDATA  = ram_q_reg;
      assign RVALID = ram_v_reg;
    end else begin : g_pipe1
      logic [WIDTH-1:0] out_data_reg;
      logic             out_valid_reg;

      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
          out_data_reg  <= '0;
          out_valid_reg <= 1'b0;
        end else begin
          out_valid_reg <= ram_v_reg;
          if (ram_v_reg) begin
            out_data_reg <= ram_q_reg;
          end
        end
      end

      assign RDATA  = out_data_reg;
      assign RVALID = out_valid_reg;
    end
  endgenerate

  assign FULL      = full_reg;
  assign EMPTY     = empty_reg;
  assign AFULL     = afull_reg;
  assign AEMPTY    = aempty_reg;
  assign LEVEL     = level_reg;
  assign OVERFLOW  = overflow_reg;
  assign UNDERFLOW = underflow_reg;

`ifdef FRAME_FIFO_PEAK_LEVEL_EN
  logic [AW:0] peak_reg;

  // Tracks the post-access level, so a clear in the same cycle as a write
  // captures the incremented value.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      peak_reg <= '0;
    end else if (PEAK_CLR) begin
      peak_reg <= level_next;
    end else if (level_next > peak_reg) begin
      peak_reg <= level_next;
    end
  end

  assign PEAK_LEVEL = peak_reg;
`endif

endmodule

// File: tb/tb_frame_fifo_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_fifo_sync_ctrl
//
// Self-checking bench for frame_fifo_sync_ctrl (DEPTH=128, PIPE=1). A
// reference FIFO model predicts flags and strobes each cycle. Accepted reads
// push {data, due edge} onto a scoreboard queue. The queue is popped when
// RVALID is expected. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_frame_fifo_sync_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int PIPE  = 1;
  localparam int AW    = 7;

  logic             CLOCK   = 1'b0;
  logic             RESET_N = 1'b1;
  logic             WE      = 1'b0;
  logic [WIDTH-1:0] WDATA   = '0;
  logic             RE      = 1'b0;
  logic [WIDTH-1:0] RDATA;
  logic             RVALID;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic [AW:0]      LEVEL;
  logic             OVERFLOW;
  logic             UNDERFLOW;
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
  logic             PEAK_CLR = 1'b0;
  logic [AW:0]      PEAK_LEVEL;
`endif

  frame_fifo_sync_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PIPE(PIPE)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .WE(WE), .WDATA(WDATA), .RE(RE),
    .RDATA(RDATA), .RVALID(RVALID), .FULL(FULL), .EMPTY(EMPTY),
    .AFULL(AFULL), .AEMPTY(AEMPTY), .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
    , .PEAK_CLR(PEAK_CLR), .PEAK_LEVEL(PEAK_LEVEL)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int edge_cnt = 0;
  always @(posedge CLOCK) edge_cnt = edge_cnt + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } rd_t;

  rd_t              rd_q[$];
  logic [WIDTH-1:0] model_q[$];
  int               mlevel    = 0;
  int               mpeak     = 0;
  logic [WIDTH-1:0] last_data = '0;
  int               vec_cnt   = 0;
  int               err_cnt   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, update model, check at next negedge.
  task automatic step(input bit we, input logic [WIDTH-1:0] wd, input bit re,
                      input bit pclr = 1'b0);
    bit wr_ok, rd_ok, ovf, udf, exp_valid;
    logic [WIDTH-1:0] d;
    WE    = we;
    WDATA = wd;
    RE    = re;
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
    PEAK_CLR = pclr;
`endif
    wr_ok = we && (mlevel < DEPTH);
    rd_ok = re && (mlevel > 0);
    ovf   = we && !wr_ok;
    udf   = re && !rd_ok;
    if (rd_ok) begin
      rd_t e;
      e.data = model_q.pop_front();
      e.due  = edge_cnt + 1 + PIPE;
      rd_q.push_back(e);
      mlevel--;
    end
    if (wr_ok) begin
      model_q.push_back(wd);
      mlevel++;
    end
    if (pclr) mpeak = mlevel;
    else if (mlevel > mpeak) mpeak = mlevel;

    @(posedge CLOCK);
    @(negedge CLOCK);
    check_val("level",     64'(LEVEL),     64'(mlevel));
    check_val("full",      64'(FULL),      64'(mlevel == DEPTH));
    check_val("empty",     64'(EMPTY),     64'(mlevel == 0));
    check_val("afull",     64'(AFULL),     64'(mlevel >= DEPTH - 4));
    check_val("aempty",    64'(AEMPTY),    64'(mlevel <= 4));
    check_val("overflow",  64'(OVERFLOW),  64'(ovf));
    check_val("underflow", 64'(UNDERFLOW), 64'(udf));
    exp_valid = (rd_q.size() > 0) && (rd_q[0].due == edge_cnt);
    check_val("rvalid", 64'(RVALID), 64'(exp_valid));
    if (exp_valid) begin
      d = rd_q[0].data;
      void'(rd_q.pop_front());
      last_data = d;
    end
    check_val("rdata", 64'(RDATA), 64'(last_data));
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
    check_val("peak", 64'(PEAK_LEVEL), 64'(mpeak));
`endif
    $display("edge %0d we=%0b re=%0b level=%0d rvalid=%0b rdata=%0h",
             edge_cnt, we, re, LEVEL, RVALID, RDATA);
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    WE = 1'b0;
    RE = 1'b0;
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
    PEAK_CLR = 1'b0;
`endif
    #2 RESET_N = 1'b0;
    #1;
    check_val("rst_level",  64'(LEVEL),     64'd0);
    check_val("rst_empty",  64'(EMPTY),     64'd1);
    check_val("rst_aempty", 64'(AEMPTY),    64'd1);
    check_val("rst_full",   64'(FULL),      64'd0);
    check_val("rst_afull",  64'(AFULL),     64'd0);
    check_val("rst_rvalid", 64'(RVALID),    64'd0);
    check_val("rst_rdata",  64'(RDATA),     64'd0);
    check_val("rst_ovf",    64'(OVERFLOW),  64'd0);
    check_val("rst_udf",    64'(UNDERFLOW), 64'd0);
`ifdef FRAME_FIFO_PEAK_LEVEL_EN
    check_val("rst_peak",   64'(PEAK_LEVEL), 64'd0);
`endif
    $display("reset applied at t=%0t", $time);
    mlevel    = 0;
    mpeak     = 0;
    last_data = '0;
    model_q.delete();
    rd_q.delete();
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

    // Fill with 0..127, then 129 reads (last one underflows), then flush.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

    // Full, then simultaneous write+read: read wins, write overflows.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

    // Steady state at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Level 60 with reads in flight, then asynchronous reset.
    for (int i = 0; i < 60; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

`ifdef FRAME_FIFO_PEAK_LEVEL_EN
    // Peak tracker: fill 90, drain to 10, clear, then add 3.
    do_reset();
    for (int i = 0; i < 90; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check_val("peak90", 64'(PEAK_LEVEL), 64'd90);
    step(1'b0, '0, 1'b0, 1'b1);
    check_val("peak10", 64'(PEAK_LEVEL), 64'd10);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    check_val("peak13", 64'(PEAK_LEVEL), 64'd13);
`endif

    check_val("scoreboard_drained", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
